// File: rtl/artec_dma_dcnv.sv
`default_nettype none
// ============================================================================
// Module      : artec_dma_dcnv
// Description : DMA read-path width down-converter. Accepts wide memory-side
//               slices (data, lane count, eof, frame number) over a
//               valid/ready stream and serialises them into narrow
//               AXI-Stream beats, raising tlast on the final beat of a frame.
//               Optional build macro ARTEC_DMA_DCNV_MSB_FIRST_EN emits lanes
//               from the highest valid lane down to lane 0.
// Revision    : 1.0 - initial release
// ============================================================================
module artec_dma_dcnv #(
  parameter int INPUT_WIDTH  = 256,
  parameter int OUTPUT_WIDTH = 32,
  parameter int FNUM_W       = 2,
  localparam int REL         = INPUT_WIDTH / OUTPUT_WIDTH,
  localparam int LW          = $clog2(REL)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    clear_i,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [INPUT_WIDTH-1:0]  s_data,
  input  logic [LW-1:0]           s_lanes,
  input  logic                    s_eof,
  input  logic [FNUM_W-1:0]       s_fnum,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [OUTPUT_WIDTH-1:0] m_tdata,
  output logic                    m_tlast,
  output logic [FNUM_W-1:0]       m_tuser,
  output logic [FNUM_W-1:0]       frame_num_o
);

  // Holding register is either empty or shifting lanes out.
  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [INPUT_WIDTH-1:0]   data_q,  data_d;
  logic [LW-1:0]            lanes_q, lanes_d;
  logic [LW-1:0]            cnt_q,   cnt_d;
  logic                     eof_q,   eof_d;
  logic [FNUM_W-1:0]        fnum_q,  fnum_d;

  logic                     w_full;
  logic                     w_last;
  logic                     w_beat;
  logic                     w_load;
  logic [LW-1:0]            w_sel;
  logic [OUTPUT_WIDTH-1:0]  w_lane [REL];

  // Split the held slice into addressable lanes.
  generate
    for (genvar g = 0; g < REL; g++) begin : g_lane
      assign w_lane[g] = data_q[g*OUTPUT_WIDTH +: OUTPUT_WIDTH];
    end
  endgenerate

  assign w_full = (state_q == ST_SHIFT);
  // cnt counts beats of the held slice; it stops at the held lane count,
  // so short slices finish early and the counter never wraps.
  assign w_last = (cnt_q == lanes_q);
  assign w_beat = w_full && m_tready;

`ifdef ARTEC_DMA_DCNV_MSB_FIRST_EN
  // Highest valid lane first; the final beat (cnt == lanes) lands on lane 0.
  assign w_sel = lanes_q - cnt_q;
`else
  // Lane 0 first, ascending up to the held lane count.
  assign w_sel = cnt_q;
`endif

  // A new slice may enter when nothing is held, or in the same cycle the
  // last beat of the held slice is taken, so slices stream without bubbles.
  assign s_ready = !w_full || (m_tready && w_last);
  assign w_load  = s_valid && s_ready;

  // Output beat is driven purely from held state, never from m_tready.
  assign m_tvalid    = w_full;
  assign m_tdata     = w_full ? w_lane[w_sel] : '0;
  assign m_tlast     = w_full && eof_q && w_last;
  assign m_tuser     = w_full ? fnum_q : '0;
  assign frame_num_o = fnum_q;

  // Next-state and slice register update; soft clear overrides any handshake.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    lanes_d = lanes_q;
    cnt_d   = cnt_q;
    eof_d   = eof_q;
    fnum_d  = fnum_q;

    case (state_q)
      ST_EMPTY: begin
        if (w_load) begin
          state_d = ST_SHIFT;
          data_d  = s_data;
          lanes_d = s_lanes;
          eof_d   = s_eof;
          fnum_d  = s_fnum;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (w_beat) begin
          if (!w_last) begin
            cnt_d = cnt_q + LW'(1);
          end else if (w_load) begin
            data_d  = s_data;
            lanes_d = s_lanes;
            eof_d   = s_eof;
            fnum_d  = s_fnum;
            cnt_d   = '0;
          end else begin
            state_d = ST_EMPTY;
          end
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    if (clear_i) begin
      state_d = ST_EMPTY;
      data_d  = '0;
      lanes_d = '0;
      cnt_d   = '0;
      eof_d   = 1'b0;
      fnum_d  = '0;
    end
  end

  // State and slice registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      lanes_q <= '0;
      cnt_q   <= '0;
      eof_q   <= 1'b0;
      fnum_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      lanes_q <= lanes_d;
      cnt_q   <= cnt_d;
      eof_q   <= eof_d;
      fnum_q  <= fnum_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_artec_dma_dcnv.sv
`default_nettype none
// ============================================================================
// Module      : tb_artec_dma_dcnv
// Description : Self-checking bench for artec_dma_dcnv: table of single
//               slices, hand-written back-to-back and clear sequences, then
//               randomized traffic against a beat-queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_artec_dma_dcnv;

  localparam int IW  = 256;
  localparam int OW  = 32;
  localparam int FW  = 2;
  localparam int REL = IW / OW;
  localparam int LW  = $clog2(REL);

  logic          clk;
  logic          rstn;
  logic          clear_i;
  logic          s_valid;
  logic          s_ready;
  logic [IW-1:0] s_data;
  logic [LW-1:0] s_lanes;
  logic          s_eof;
  logic [FW-1:0] s_fnum;
  logic          m_tvalid;
  logic          m_tready;
  logic [OW-1:0] m_tdata;
  logic          m_tlast;
  logic [FW-1:0] m_tuser;
  logic [FW-1:0] frame_num_o;

  artec_dma_dcnv #(
    .INPUT_WIDTH (IW),
    .OUTPUT_WIDTH(OW),
    .FNUM_W      (FW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .clear_i    (clear_i),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_lanes    (s_lanes),
    .s_eof      (s_eof),
    .s_fnum     (s_fnum),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tdata    (m_tdata),
    .m_tlast    (m_tlast),
    .m_tuser    (m_tuser),
    .frame_num_o(frame_num_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] d;
    logic          l;
    logic [FW-1:0] u;
  } beat_t;

  typedef struct {
    int            lanes;
    logic          eof;
    logic [FW-1:0] fnum;
    logic [31:0]   base;
    int            exp_beats;
    logic          exp_last;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Which lane the j-th beat of a slice with the given lane count carries.
  function automatic int lane_of(input int lanes, input int j);
`ifdef ARTEC_DMA_DCNV_MSB_FIRST_EN
    return lanes - j;
`else
    return j;
`endif
  endfunction

  function automatic logic [IW-1:0] mk_data(input logic [31:0] base);
    logic [IW-1:0] d;
    for (int k = 0; k < REL; k++) d[k*OW +: OW] = base + 32'(k);
    return d;
  endfunction

  task automatic drive_slice(input int lanes, input logic eof, input logic [FW-1:0] fnum,
                             input logic [31:0] base);
    s_valid = 1'b1;
    s_lanes = LW'(lanes);
    s_eof   = eof;
    s_fnum  = fnum;
    s_data  = mk_data(base);
  endtask

  // One slice alone with the sink always ready.
  task automatic run_single(input vec_t v);
    @(negedge clk);
    drive_slice(v.lanes, v.eof, v.fnum, v.base);
    m_tready = 1'b1;
    #1;
    chk("single_ready_empty", 64'(s_ready), 64'd1);
    @(negedge clk);
    s_valid = 1'b0;
    for (int j = 0; j < v.exp_beats; j++) begin
      if (j > 0) @(negedge clk);
      #1;
      chk("single_tvalid", 64'(m_tvalid), 64'd1);
      chk("single_tdata",  64'(m_tdata), 64'(v.base + 32'(lane_of(v.lanes, j))));
      chk("single_tlast",  64'(m_tlast), 64'(v.exp_last && (j == v.exp_beats - 1)));
      chk("single_tuser",  64'(m_tuser), 64'(v.fnum));
      chk("single_sready", 64'(s_ready), 64'(j == v.exp_beats - 1));
    end
    @(negedge clk);
    #1;
    chk("single_idle_tvalid", 64'(m_tvalid), 64'd0);
    chk("single_frame_num",   64'(frame_num_o), 64'(v.fnum));
  endtask

  // Two slices offered back to back; beats must be contiguous.
  task automatic run_b2b(input vec_t a, input vec_t b);
    int na;
    int nb;
    na = a.lanes + 1;
    nb = b.lanes + 1;
    m_tready = 1'b1;
    @(negedge clk);
    drive_slice(a.lanes, a.eof, a.fnum, a.base);
    #1;
    chk("b2b_ready_empty", 64'(s_ready), 64'd1);
    @(negedge clk);
    drive_slice(b.lanes, b.eof, b.fnum, b.base);
    for (int j = 0; j < na + nb; j++) begin
      vec_t v;
      int   jj;
      if (j > 0) @(negedge clk);
      if (j == na) s_valid = 1'b0;
      v  = (j < na) ? a : b;
      jj = (j < na) ? j : j - na;
      #1;
      chk("b2b_tvalid", 64'(m_tvalid), 64'd1);
      chk("b2b_tdata",  64'(m_tdata), 64'(v.base + 32'(lane_of(v.lanes, jj))));
      chk("b2b_tuser",  64'(m_tuser), 64'(v.fnum));
      chk("b2b_tlast",  64'(m_tlast), 64'(v.eof && (jj == v.lanes)));
      chk("b2b_sready", 64'(s_ready), 64'(jj == v.lanes));
    end
    @(negedge clk);
    #1;
    chk("b2b_idle_tvalid", 64'(m_tvalid), 64'd0);
  endtask

  vec_t  vecs[6];
  beat_t q[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FW-1:0] exp_fnum;
    logic          exp_rdy;
    logic          acc_prev;

    vecs[0] = '{lanes: 7, eof: 1'b0, fnum: 2'd0, base: 32'hA000_0000, exp_beats: 8, exp_last: 1'b0};
    vecs[1] = '{lanes: 2, eof: 1'b1, fnum: 2'd3, base: 32'hB000_0010, exp_beats: 3, exp_last: 1'b1};
    vecs[2] = '{lanes: 0, eof: 1'b1, fnum: 2'd1, base: 32'hC000_0020, exp_beats: 1, exp_last: 1'b1};
    vecs[3] = '{lanes: 0, eof: 1'b0, fnum: 2'd2, base: 32'h1234_5600, exp_beats: 1, exp_last: 1'b0};
    vecs[4] = '{lanes: 5, eof: 1'b0, fnum: 2'd1, base: 32'h5555_0000, exp_beats: 6, exp_last: 1'b0};
    vecs[5] = '{lanes: 7, eof: 1'b1, fnum: 2'd2, base: 32'hEE00_0100, exp_beats: 8, exp_last: 1'b1};

    rstn     = 1'b0;
    clear_i  = 1'b0;
    s_valid  = 1'b0;
    s_data   = '0;
    s_lanes  = '0;
    s_eof    = 1'b0;
    s_fnum   = '0;
    m_tready = 1'b0;

    // Reset held across two rising edges.
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_tvalid",    64'(m_tvalid), 64'd0);
    chk("rst_sready",    64'(s_ready), 64'd1);
    chk("rst_frame_num", 64'(frame_num_o), 64'd0);
    chk("rst_tdata",     64'(m_tdata), 64'd0);
    chk("rst_tlast",     64'(m_tlast), 64'd0);
    chk("rst_tuser",     64'(m_tuser), 64'd0);
    rstn = 1'b1;

    for (int i = 0; i < 6; i++) run_single(vecs[i]);

    // Full slice fnum 1 followed by eof slice fnum 2.
    run_b2b('{lanes: 7, eof: 1'b0, fnum: 2'd1, base: 32'h1100_0000, exp_beats: 8, exp_last: 1'b0},
            '{lanes: 7, eof: 1'b1, fnum: 2'd2, base: 32'h2200_0000, exp_beats: 8, exp_last: 1'b1});
    // Partial eof slice, next slice must start the very next cycle.
    run_b2b('{lanes: 2, eof: 1'b1, fnum: 2'd3, base: 32'h3300_0000, exp_beats: 3, exp_last: 1'b1},
            '{lanes: 1, eof: 1'b1, fnum: 2'd0, base: 32'h4400_0000, exp_beats: 2, exp_last: 1'b1});

    // Soft clear in the middle of a slice.
    m_tready = 1'b1;
    @(negedge clk);
    drive_slice(7, 1'b1, 2'd3, 32'hD000_0000);
    @(negedge clk);
    s_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      if (j > 0) @(negedge clk);
      #1;
      chk("clr_pre_tdata", 64'(m_tdata), 64'(32'hD000_0000 + 32'(lane_of(7, j))));
    end
    @(negedge clk);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    #1;
    chk("clr_tvalid",    64'(m_tvalid), 64'd0);
    chk("clr_sready",    64'(s_ready), 64'd1);
    chk("clr_frame_num", 64'(frame_num_o), 64'd0);
    chk("clr_tdata",     64'(m_tdata), 64'd0);
    chk("clr_tlast",     64'(m_tlast), 64'd0);
    run_single('{lanes: 7, eof: 1'b0, fnum: 2'd1, base: 32'hF000_0000, exp_beats: 8, exp_last: 1'b0});

    // Clear wins over a handshake offered in the same cycle.
    @(negedge clk);
    drive_slice(3, 1'b1, 2'd2, 32'h7700_0000);
    clear_i = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    clear_i = 1'b0;
    #1;
    chk("clr_hs_tvalid",    64'(m_tvalid), 64'd0);
    chk("clr_hs_frame_num", 64'(frame_num_o), 64'd0);

    // Randomized traffic with backpressure and occasional clears.
    exp_fnum = '0;
    acc_prev = 1'b0;
    q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (!s_valid || acc_prev) begin
        s_valid = ($urandom_range(0, 3) != 0);
        s_lanes = LW'($urandom_range(0, REL - 1));
        s_eof   = 1'($urandom);
        s_fnum  = FW'($urandom);
        for (int k = 0; k < REL; k++) s_data[k*OW +: OW] = $urandom;
      end
      m_tready = 1'($urandom);
      clear_i  = ($urandom_range(0, 149) == 0);
      #1;
      chk("rnd_tvalid", 64'(m_tvalid), 64'(q.size() > 0));
      if (q.size() > 0) begin
        chk("rnd_tdata", 64'(m_tdata), 64'(q[0].d));
        chk("rnd_tlast", 64'(m_tlast), 64'(q[0].l));
        chk("rnd_tuser", 64'(m_tuser), 64'(q[0].u));
      end
      exp_rdy = (q.size() == 0) || (m_tready && (q.size() == 1));
      chk("rnd_sready",    64'(s_ready), 64'(exp_rdy));
      chk("rnd_frame_num", 64'(frame_num_o), 64'(exp_fnum));

      acc_prev = 1'b0;
      if (clear_i) begin
        q.delete();
        exp_fnum = '0;
      end else begin
        if ((q.size() > 0) && m_tready) void'(q.pop_front());
        if (s_valid && exp_rdy) begin
          acc_prev = 1'b1;
          exp_fnum = s_fnum;
          for (int j = 0; j <= int'(s_lanes); j++) begin
            beat_t b;
            b.d = s_data[lane_of(int'(s_lanes), j)*OW +: OW];
            b.l = s_eof && (j == int'(s_lanes));
            b.u = s_fnum;
            q.push_back(b);
          end
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
